// File: rtl/uc_multiciclo.sv
// Multicycle control unit: IDLE/FETCH/EXEC/HALT sequencer with opcode decode, run/halt handshake, retired count.
// Latency: one instruction every 2 clocks (FETCH then EXEC); decoded controls are combinational in EXEC only.
// No backpressure: start is sampled only in IDLE/HALT; UC_ILLEGAL_TRAP_EN makes illegal opcodes halt instead of NOP.
module uc_multiciclo #(
  parameter int CNT_W      = 16,
  parameter bit AUTO_START = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Opcode,
  input  logic             z,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   illegal_op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      icount  <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == EXEC) begin
        if (icount != {CNT_W{1'b1}})
          icount <= icount + CNT_W'(1);
        if (illegal_op)
          illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    s_inc      = 1'b1;
    s_inm      = 1'b0;
    we3        = 1'b0;
    wez        = 1'b0;
    Op         = 3'b000;
    pc_en      = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      IDLE: begin
        if (start || AUTO_START)
          state_nxt = FETCH;
      end
      FETCH: state_nxt = EXEC;
      EXEC: begin
        pc_en     = 1'b1;
        state_nxt = FETCH;
        if (Opcode[5]) begin
          Op  = Opcode[4:2];
          we3 = 1'b1;
          wez = 1'b1;
        end else if (Opcode[4:2] == 3'b000) begin
          s_inm = 1'b1;
          we3   = 1'b1;
        end else begin
          case (Opcode)
            6'b000100: s_inc = 1'b0;
            6'b000101: s_inc = ~z;
            6'b000110: s_inc = z;
            6'b000111: s_inc = 1'b1;
            6'b001111: state_nxt = HALT;
            default: begin
              // Unknown opcodes retire with no side effects other than the sticky flag.
              illegal_op = 1'b1;
`ifdef UC_ILLEGAL_TRAP_EN
              state_nxt  = HALT;
`endif
            end
          endcase
        end
      end
      HALT: begin
        halted = 1'b1;
        if (start)
          state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo with CNT_W=4 so counter saturation is reachable quickly.
module tb_uc_multiciclo;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [5:0]       Opcode;
  logic             z;
  logic             s_inc, s_inm, we3, wez, pc_en, halted, illegal;
  logic [2:0]       Op;
  logic [CNT_W-1:0] icount;

  int n_asserts = 0;
  int n_fails   = 0;
  int exp_cnt;

  uc_multiciclo #(.CNT_W(CNT_W), .AUTO_START(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .Opcode(Opcode), .z(z),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .pc_en(pc_en), .halted(halted), .illegal(illegal), .icount(icount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enables as a packed vector {s_inc, s_inm, we3, wez, Op, pc_en, halted}
  function automatic logic [31:0] ctl();
    return {23'd0, s_inc, s_inm, we3, wez, Op, pc_en, halted};
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; Opcode = 6'b000111; z = 1'b0;
    step(); step();
    check("reset_ctl", ctl(), {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
    check("reset_cnt", icount, 0);
    check("reset_illegal", illegal, 0);

    // ALU op 100100 -> Op=001
    #2 reset = 1'b1;
    Opcode = 6'b100100; start = 1'b1;
    step();
    start = 1'b0;
    check("alu_fetch", ctl(), {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
    step();
    check("alu_exec", ctl(), {23'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 1'b0});
    step();
    check("alu_after", ctl(), {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
    check("alu_cnt", icount, 1);

    // Reset asserted in the middle of EXEC
    step();
    check("mid_exec_we3", we3, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_ctl", ctl(), {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});
    check("abort_cnt", icount, 0);
    step();
    check("idle_hold", pc_en, 0);
    #2 reset = 1'b1;

    // JZ both polarities of z
    Opcode = 6'b000101; z = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    step();
    check("jz_z1", {s_inc, pc_en, we3}, 3'b010);
    z = 1'b0; #1;
    check("jz_z0", s_inc, 1);

    // JNZ both polarities of z
    step(); Opcode = 6'b000110; z = 1'b1;
    step();
    check("jnz_z1", {s_inc, pc_en, we3}, 3'b110);
    z = 1'b0; #1;
    check("jnz_z0", s_inc, 0);

    // LOADI
    step(); Opcode = 6'b000011;
    step();
    check("loadi", ctl(), {23'd0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0});

    // J
    step(); Opcode = 6'b000100;
    step();
    check("jump", ctl(), {23'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0});

    // HALT and resume
    step(); Opcode = 6'b001111;
    step();
    check("halt_exec", ctl(), {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0});
    step();
    check("halt_state", ctl(), {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1});
    check("halt_cnt", icount, 5);
    step();
    check("halt_stays", halted, 1);
    start = 1'b1;
    step(); start = 1'b0;
    check("resume_fetch", ctl(), {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0});

    // Illegal opcode 010000
    Opcode = 6'b010000;
    step();
    check("illegal_exec", {we3, wez, s_inm, Op, pc_en, s_inc}, 8'b000_000_11);
    check("illegal_not_yet", illegal, 0);
    step();
    check("illegal_flag", illegal, 1);
    check("illegal_cnt", icount, 6);
`ifdef UC_ILLEGAL_TRAP_EN
    check("illegal_trap_halt", halted, 1);
    start = 1'b1;
    step(); start = 1'b0;
`else
    check("illegal_nop_fetch", {halted, pc_en}, 2'b00);
`endif

    // 17 NOPs -> counter saturates at 15
    Opcode = 6'b000111;
    exp_cnt = 6;
    for (int i = 0; i < 17; i++) begin
      step();
      step();
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      check($sformatf("nop_cnt_%0d", i), icount, exp_cnt);
    end
    check("sat_cnt", icount, 15);
    check("illegal_sticky", illegal, 1);

    #2 reset = 1'b0;
    #1;
    check("final_reset_cnt", icount, 0);
    check("final_reset_illegal", illegal, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
